// File: rtl/rca40_mp_seq.sv
// Multi-word adder: one shared 40-bit ripple-carry adder walks WORDS operand words LSW first.
// Optional macro MP_SUB_EN makes in_sub request A-B (capture ~B, carry-in 1).

module rca40 (
    input  logic [39:0] a,
    input  logic [39:0] b,
    input  logic        cin,
    output logic [39:0] s,
    output logic        cout
);
    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < 40; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module rca40_mp_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [40*WORDS-1:0] in_a,
    input  logic [40*WORDS-1:0] in_b,
    input  logic                in_cin,
    input  logic                in_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [40*WORDS-1:0] out_sum,
    output logic                out_cout,
    output logic                busy
);
    localparam int W  = 40 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    opa_reg, opb_reg, sum_reg;
    logic [IW-1:0]   idx_reg;
    logic            carry_reg, cout_reg;
    logic [39:0]     a_words [WORDS];
    logic [39:0]     b_words [WORDS];
    logic [39:0]     a_sel, b_sel, rca_s;
    logic            rca_cout, last_word;
    logic [W-1:0]    opb_capture;
    logic            carry_capture;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign a_words[gi] = opa_reg[40*gi +: 40];
            assign b_words[gi] = opb_reg[40*gi +: 40];
        end
    endgenerate

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_reg == IW'(i)) begin
                a_sel = a_words[i];
                b_sel = b_words[i];
            end
        end
    end

    rca40 u_rca (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (carry_reg),
        .s    (rca_s),
        .cout (rca_cout)
    );

    assign last_word = (idx_reg == IW'(WORDS - 1));

`ifdef MP_SUB_EN
    // Subtraction as A + ~B + 1; in_cin has no meaning for a subtract.
    assign opb_capture   = in_sub ? ~in_b : in_b;
    assign carry_capture = in_sub ? 1'b1 : in_cin;
`else
    logic unused_sub;
    assign unused_sub    = in_sub;
    assign opb_capture   = in_b;
    assign carry_capture = in_cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_reg   <= '0;
            opb_reg   <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        opa_reg   <= in_a;
                        opb_reg   <= opb_capture;
                        carry_reg <= carry_capture;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx_reg == IW'(i)) sum_reg[40*i +: 40] <= rca_s;
                    end
                    carry_reg <= rca_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_word) cout_reg <= rca_cout;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN) || (state_reg == DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
endmodule

// File: tb/tb_rca40_mp_seq.sv
// Self-checking bench for rca40_mp_seq (WORDS=4): vector table plus scoreboard queue,
// with hand-written backpressure and mid-run reset sequences.

module tb_rca40_mp_seq;
    localparam int WORDS = 4;
    localparam int W     = 40 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_cin, in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           hold;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    vec_t vecs [8];
    exp_t exp_q [$];

    rca40_mp_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Issue one operation; rst_at >= 0 aborts it with reset once idx reaches rst_at.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] es, input logic ec,
                          input int hold, input int rst_at);
        exp_t         e;
        int           lat;
        logic [W-1:0] held_sum;
        logic         held_cout;
        @(negedge clk);
        check("in_ready_idle", {{W{1'b0}}, in_ready}, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        exp_q.push_back('{sum: es, cout: ec});
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = rand_word();
        in_cin   = ~cin;
        in_sub   = ~sub;
        check("run_busy", {{W{1'b0}}, busy}, 1);
        check("run_in_ready", {{W{1'b0}}, in_ready}, 0);
        if (rst_at >= 0) begin
            repeat (rst_at) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_out_valid", {{W{1'b0}}, out_valid}, 0);
            check("abort_out_sum", {1'b0, out_sum}, 0);
            check("abort_out_cout", {{W{1'b0}}, out_cout}, 0);
            check("abort_in_ready", {{W{1'b0}}, in_ready}, 1);
            check("abort_busy", {{W{1'b0}}, busy}, 0);
            exp_q.delete();
            $display("txn %0d aborted by reset at idx=%0d", txn, rst_at);
            txn++;
            return;
        end
        lat = 0;
        while (!out_valid && lat < 4 * WORDS + 10) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout actual=0 expected=1 after %0d cycles", lat);
            void'(exp_q.pop_front());
            return;
        end
        check("latency", (W+1)'(lat), (W+1)'(WORDS));
        e = exp_q.pop_front();
        check("out_sum", {1'b0, out_sum}, {1'b0, e.sum});
        check("out_cout", {{W{1'b0}}, out_cout}, {{W{1'b0}}, e.cout});
        $display("txn %0d a=%h b=%h cin=%0d sub=%0d sum=%h cout=%0d lat=%0d",
                 txn, a, b, cin, sub, out_sum, out_cout, lat);
        txn++;
        held_sum  = out_sum;
        held_cout = out_cout;
        for (int h = 0; h < hold; h++) begin
            in_a     = rand_word();
            in_valid = ~in_valid;
            @(negedge clk);
            check("hold_sum", {1'b0, out_sum}, {1'b0, held_sum});
            check("hold_cout", {{W{1'b0}}, out_cout}, {{W{1'b0}}, held_cout});
            check("hold_in_ready", {{W{1'b0}}, in_ready}, 0);
            check("hold_out_valid", {{W{1'b0}}, out_valid}, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", {{W{1'b0}}, out_valid}, 0);
        check("post_in_ready", {{W{1'b0}}, in_ready}, 1);
        check("post_sum_kept", {1'b0, out_sum}, {1'b0, held_sum});
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] ra, rb;
        logic [W:0]   ref_sum;
        logic         rc;
        ones = '1;

        vecs[0] = '{a: W'(40'hFF_FFFF_FFFF), b: W'(1), cin: 1'b0, sub: 1'b0,
                    exp_sum: W'(44'h100_0000_0000), exp_cout: 1'b0, hold: 5};
        vecs[1] = '{a: ones, b: '0, cin: 1'b1, sub: 1'b0,
                    exp_sum: '0, exp_cout: 1'b1, hold: 0};
        vecs[2] = '{a: ones, b: ones, cin: 1'b1, sub: 1'b0,
                    exp_sum: ones, exp_cout: 1'b1, hold: 1};
        vecs[3] = '{a: '0, b: '0, cin: 1'b0, sub: 1'b0,
                    exp_sum: '0, exp_cout: 1'b0, hold: 0};
        vecs[4] = '{a: {1'b1, {(W-1){1'b0}}}, b: {1'b1, {(W-1){1'b0}}}, cin: 1'b0, sub: 1'b0,
                    exp_sum: '0, exp_cout: 1'b1, hold: 0};
        vecs[5] = '{a: W'(40'h80_0000_0000), b: W'(40'h80_0000_0000), cin: 1'b1, sub: 1'b0,
                    exp_sum: W'(44'h100_0000_0001), exp_cout: 1'b0, hold: 0};
`ifdef MP_SUB_EN
        vecs[6] = '{a: W'(5), b: W'(7), cin: 1'b0, sub: 1'b1,
                    exp_sum: {{(W-1){1'b1}}, 1'b0}, exp_cout: 1'b0, hold: 0};
        vecs[7] = '{a: W'(7), b: W'(5), cin: 1'b0, sub: 1'b1,
                    exp_sum: W'(2), exp_cout: 1'b1, hold: 0};
`else
        vecs[6] = '{a: W'(5), b: W'(7), cin: 1'b0, sub: 1'b1,
                    exp_sum: W'(12), exp_cout: 1'b0, hold: 0};
        vecs[7] = '{a: W'(7), b: W'(5), cin: 1'b1, sub: 1'b1,
                    exp_sum: W'(13), exp_cout: 1'b0, hold: 0};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
        check("rst_out_sum", {1'b0, out_sum}, 0);
        check("rst_out_cout", {{W{1'b0}}, out_cout}, 0);
        check("rst_busy", {{W{1'b0}}, busy}, 0);
        check("rst_in_ready", {{W{1'b0}}, in_ready}, 1);
        repeat (10) @(negedge clk);
        check("idle_out_valid", {{W{1'b0}}, out_valid}, 0);
        check("idle_out_sum", {1'b0, out_sum}, 0);
        check("idle_busy", {{W{1'b0}}, busy}, 0);
        check("idle_in_ready", {{W{1'b0}}, in_ready}, 1);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].hold, -1);

        // Leave a nonzero result so the abort visibly clears out_sum.
        ra = rand_word(); rb = rand_word(); rc = 1'b1;
        ref_sum = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
        run_op(ra, rb, rc, 1'b0, ref_sum[W-1:0], ref_sum[W], 0, -1);
        run_op(rand_word(), rand_word(), 1'b1, 1'b0, '0, 1'b0, 0, 2);

        for (int k = 0; k < 4; k++) begin
            ra = rand_word(); rb = rand_word(); rc = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            run_op(ra, rb, rc, 1'b0, ref_sum[W-1:0], ref_sum[W], k, -1);
        end

        check("scoreboard_empty", (W+1)'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rca40_mp_seq.md
Name: rca40_mp_seq

Overview:
Multi-cycle sequencer that performs a WORDS×40-bit addition using one shared rca40 instance, one 40-bit word per clock, LSW first. The carry is registered between words. Operands are accepted, and results returned, over valid/ready handshakes. It sits between a wide-operand producer (ALU/crypto front end) and its consumer, so a 160-bit or wider add costs one 40-bit adder instead of a wide combinational chain.

Parameters:
WORDS, 4, number of 40-bit words per operand; legal range 1..16; operand width W = 40*WORDS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  initial carry into word 0
in_sub  input  1  subtract request; used only with MP_SUB_EN, ignored otherwise
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  registered sum
out_cout  output  1  carry out of the top word
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst sampled high at an edge forces the following, regardless of current state:
  - state=IDLE, word index=0, carry reg=0
  - out_sum=0, out_cout=0, out_valid=0, busy=0
  - in_ready=1 in the cycle after reset
  - reset during RUN or DONE aborts the operation; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a and in_b into internal operand registers, idx<=0, carry<=in_cin, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, the rca40 instance is driven with A=opa[40*idx+:40], B=opb[40*idx+:40], Cin=carry.
  - At the edge: sum_reg[40*idx+:40]<=S, carry<=Cout, idx<=idx+1.
  - When idx==WORDS-1, the same edge also sets out_cout<=Cout and moves to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout are held stable.
  - On out_ready: out_valid<=0 and go to IDLE.
  - in_ready=0 in DONE; a request is never accepted in the same cycle a result is accepted.
- Latency: for an acceptance edge at cycle 0, out_valid goes high after edge WORDS.
  - Minimum issue interval is WORDS+2 cycles with out_ready held high.
- Input changes after acceptance are ignored; the operand registers are the only source.
- out_sum is updated only in RUN. Between results it keeps the last value; out_cout likewise.
- Arithmetic is modulo 2^W. out_cout is the carry out of bit W-1.
- WORDS=1: RUN lasts one cycle; behaviour equals a registered single rca40 add.
- out_ready is ignored outside DONE.

Optional Feature:
MP_SUB_EN
- Defined: at acceptance, if in_sub=1, the operand register captures ~in_b and the carry reg captures 1; in_cin is ignored.
  - The result is A-B mod 2^W.
  - out_cout=1 means no borrow (A>=B unsigned).
  - If in_sub=0, behaviour is identical to the add path.
- Undefined: the in_sub port remains present but is unused; all operations are additions with in_cin.

Test Plan:
1. Reset then idle: after rst, out_valid=0, out_sum=0, busy=0, in_ready=1; hold out_ready=0 for 10 cycles -> no change.
2. Cross-word carry (WORDS=4): A=0x0000000000_0000000000_0000000000_FFFFFFFFFF, B=1, cin=0 -> after 4 edges, out_sum=0x...01_0000000000, out_cout=0; out_valid rises exactly 4 edges after acceptance.
3. Full ripple: A=all-ones (160 bits), B=0, cin=1 -> out_sum=0, out_cout=1.
4. Backpressure and stale inputs: hold out_ready=0 for 5 cycles in DONE and toggle in_a/in_valid -> out_sum, out_cout stable, in_ready=0; release out_ready -> one handshake, then IDLE.
5. Reset mid-RUN: rst at idx=2 -> next cycle out_valid=0, out_sum=0, in_ready=1; a new request then completes correctly with random A/B compared against a 160-bit reference sum.
6. MP_SUB_EN: A=5, B=7, in_sub=1 -> out_sum=2^160-2, out_cout=0; A=7, B=5 -> out_sum=2, out_cout=1.
